// File: rtl/seq_detect_ctrl.sv
// Run-controlled serial pattern detector: programmable pattern/length/overlap,
// match target with saturating counter, and a no-match timeout.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               done,
  output logic               timed_out,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam logic [MAX_LEN-1:0] PATTERN_RST = MAX_LEN'(7);
  localparam logic [LEN_W-1:0]   LEN_RST     = LEN_W'(3);
  localparam logic [LEN_W-1:0]   LEN_MAX     = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]   TARGET_RST  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [TO_W-1:0]    timeout_q, timeout_d;

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               busy_q, busy_d;
  logic               match_pulse_q, match_pulse_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [CNT_W-1:0]   count_inc;
  logic               len_ok;
  logic               hit;
  logic               to_expire;

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc   = (fill_q >= LEN_MAX) ? fill_q : fill_q + 1'b1;
    count_inc  = (&count_q) ? count_q : count_q + 1'b1;
    len_ok     = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    to_expire  = (timeout_q != '0) && (to_cnt_q == timeout_q - 1'b1);

    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    // Match is judged on the post-shift history of this beat.
    hit = (state_q == HUNT) && in_valid && (fill_inc >= len_q) &&
          (((hist_shift ^ pattern_q) & len_mask) == '0);
  end

  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    len_d         = len_q;
    overlap_d     = overlap_q;
    target_d      = target_q;
    timeout_d     = timeout_q;
    hist_d        = hist_q;
    fill_d        = fill_q;
    to_cnt_d      = to_cnt_q;
    count_d       = count_q;
    match_pulse_d = 1'b0;
    cfg_err_d     = 1'b0;

    if (cfg_we) begin
      if ((state_q != HUNT) && len_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        target_d  = cfg_target;
        timeout_d = cfg_timeout;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (abort) begin
      state_d = IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            state_d  = HUNT;
            count_d  = '0;
            hist_d   = '0;
            fill_d   = '0;
            to_cnt_d = '0;
          end
        end
        HUNT: begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
          end
          if (hit) begin
            match_pulse_d = 1'b1;
            count_d       = count_inc;
            to_cnt_d      = '0;
            if (!overlap_q) fill_d = '0;
            if ((target_q != '0) && (count_inc == target_q)) state_d = DONE;
          end else if (to_expire) begin
            state_d = TIMEOUT;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d      = (state_d == HUNT);
    done_d      = (state_d == DONE);
    timed_out_d = (state_d == TIMEOUT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pattern_q     <= PATTERN_RST;
      len_q         <= LEN_RST;
      overlap_q     <= 1'b0;
      target_q      <= TARGET_RST;
      timeout_q     <= '0;
      hist_q        <= '0;
      fill_q        <= '0;
      to_cnt_q      <= '0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      match_pulse_q <= 1'b0;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      len_q         <= len_d;
      overlap_q     <= overlap_d;
      target_q      <= target_d;
      timeout_q     <= timeout_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      to_cnt_q      <= to_cnt_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      match_pulse_q <= match_pulse_d;
      done_q        <= done_d;
      timed_out_q   <= timed_out_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign busy        = busy_q;
  assign match_pulse = match_pulse_q;
  assign match_count = count_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboarded bench for seq_detect_ctrl: inputs driven on negedge, outputs
// sampled on the following negedge.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_target = '0;
  logic [15:0] cfg_timeout = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       busy, match_pulse, done, timed_out, cfg_err;
  logic [7:0] match_count;

  typedef struct {
    logic       pulse;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = '0;
  string      cur_test = "none";

  seq_detect_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .cfg_timeout(cfg_timeout), .start(start), .abort(abort),
    .in_valid(in_valid), .in_bit(in_bit), .busy(busy), .match_pulse(match_pulse),
    .match_count(match_count), .done(done), .timed_out(timed_out), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                           input logic [7:0] tgt, input logic [15:0] to);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_target = tgt; cfg_timeout = to;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    exp_cnt = '0;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s start_busy got %b want 1", cur_test, busy);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // One input cycle: expected result is queued at drive time, compared when the DUT answers.
  task automatic beat(input logic v, input logic b, input logic exp_pulse);
    exp_t e;
    in_valid = v; in_bit = b;
    if (exp_pulse) exp_cnt = exp_cnt + 1'b1;
    e.pulse = exp_pulse; e.cnt = exp_cnt;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (match_pulse !== e.pulse) begin
      errors++; $display("FAIL %s match_pulse got %b want %b", cur_test, match_pulse, e.pulse);
    end
    checks++;
    if (match_count !== e.cnt) begin
      errors++; $display("FAIL %s match_count got %0d want %0d", cur_test, match_count, e.cnt);
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({busy, match_pulse, done, timed_out, cfg_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {busy, match_pulse, done, timed_out, cfg_err});
    end
    checks++;
    if (match_count !== 8'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", match_count);
    end
  endtask

  task automatic test_default_match();
    cur_test = "default_111";
    do_start();
    beat(1, 1, 0); beat(1, 1, 0); beat(1, 1, 1);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL default_done done/busy got %b want 10", {done, busy});
    end
    beat(0, 0, 0);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL default_done_hold got %b want 1", done);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] stream = 7'b1011011;
    logic [6:0] hits   = 7'b0001001;
    cur_test = "overlap";
    cfg_write(8'b1011, 4'd4, 1'b1, 8'd0, 16'd0);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL overlap_cfg_err got %b want 0", cfg_err);
    end
    do_start();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL overlap_done_clear got %b want 0", done);
    end
    for (int i = 6; i >= 0; i--) beat(1, stream[i], hits[i]);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL overlap_busy got %b want 1", busy);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] stream = 7'b1011011;
    logic [6:0] hits   = 7'b0001000;
    cur_test = "nonoverlap";
    do_abort();
    checks++;
    if ({busy, match_count} !== {1'b0, 8'd2}) begin
      errors++; $display("FAIL abort_hold busy/count got %b/%0d want 0/2", busy, match_count);
    end
    cfg_write(8'b1011, 4'd4, 1'b0, 8'd0, 16'd0);
    do_start();
    for (int i = 6; i >= 0; i--) beat(1, stream[i], hits[i]);
  endtask

  task automatic test_cfg_err();
    logic [6:0] stream = 7'b1011011;
    logic [6:0] hits   = 7'b0001000;
    cur_test = "cfg_err";
    cfg_write(8'b0000, 4'd4, 1'b1, 8'd0, 16'd0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL cfg_err_hunt got %b want 1", cfg_err);
    end
    step();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL cfg_err_pulse_width got %b want 0", cfg_err);
    end
    do_abort();
    cfg_write(8'b0000, 4'd0, 1'b1, 8'd0, 16'd0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL cfg_err_len0 got %b want 1", cfg_err);
    end
    cfg_write(8'b0000, 4'd9, 1'b1, 8'd0, 16'd0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL cfg_err_len9 got %b want 1", cfg_err);
    end
    do_start();
    for (int i = 6; i >= 0; i--) beat(1, stream[i], hits[i]);
  endtask

  task automatic test_timeout();
    cur_test = "timeout";
    do_abort();
    cfg_write(8'b1011, 4'd4, 1'b0, 8'd0, 16'd5);
    do_start();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (k < 5 && {timed_out, busy} !== 2'b01) begin
        errors++; $display("FAIL timeout_early cycle %0d got %b want 01", k, {timed_out, busy});
      end else if (k == 5 && {timed_out, busy} !== 2'b10) begin
        errors++; $display("FAIL timeout_expire cycle %0d got %b want 10", k, {timed_out, busy});
      end
    end
  endtask

  task automatic test_abort_start_done();
    cur_test = "abort_start";
    cfg_write(8'b111, 4'd3, 1'b0, 8'd1, 16'd0);
    do_start();
    checks++;
    if (timed_out !== 1'b0) begin
      errors++; $display("FAIL restart_timed_out got %b want 0", timed_out);
    end
    beat(1, 1, 0); beat(1, 1, 0); beat(1, 1, 1);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, done, timed_out, match_count} !== {3'b000, 8'd1}) begin
      errors++; $display("FAIL abort_start flags/count got %b/%0d want 000/1",
                         {busy, done, timed_out}, match_count);
    end
    beat(1, 1, 0); beat(1, 1, 0); beat(1, 1, 0);
  endtask

  task automatic test_reset_mid();
    cur_test = "reset_mid";
    cfg_write(8'b1011, 4'd4, 1'b1, 8'd0, 16'd0);
    do_start();
    beat(1, 1, 0); beat(1, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({busy, match_pulse, done, timed_out, cfg_err, match_count} !== 13'd0) begin
      errors++; $display("FAIL reset_mid flags/count got %b/%0d want 00000/0",
                         {busy, match_pulse, done, timed_out, cfg_err}, match_count);
    end
    do_start();
    beat(1, 1, 0); beat(0, 0, 0); beat(1, 1, 0); beat(0, 1, 0); beat(1, 1, 1);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL reset_mid_default done/busy got %b want 10", {done, busy});
    end
  endtask

  initial begin
    test_reset();
    test_default_match();
    test_overlap();
    test_nonoverlap();
    test_cfg_err();
    test_timeout();
    test_abort_start_done();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
